// File: rtl/ir_array_sampler.sv
`timescale 1ns/1ps
// Multi-channel IR reflectance sampler: charge, time the discharge per channel, debounce black/white.
// Define IR_INPUT_SYNC_EN to add a 2-flop synchroniser on every in_signal bit.
module ir_array_sampler #(
  parameter int CHANNELS      = 8,
  parameter int CHARGE_CYCLES = 2048,
  parameter int TIMEOUT       = 2000,
  parameter int THRESHOLD     = 1000,
  parameter int BLACK_HITS    = 8,
  localparam int CW           = $clog2(TIMEOUT + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CHANNELS-1:0]    in_signal,
  output logic [CHANNELS-1:0]    drive_out,
  output logic [CHANNELS*CW-1:0] times,
  output logic [CHANNELS-1:0]    black,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int KW = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, PUBLISH} state_t;

  state_t state, nextState;
  logic [KW-1:0]       chargeCnt;
  logic [CW-1:0]       measCnt;
  logic [CW-1:0]       capVal [CHANNELS];
  logic [5:0]          hitCnt [CHANNELS];
  logic [CHANNELS-1:0] captured;
  logic [CHANNELS-1:0] inSync;
  logic [CHANNELS-1:0] hitNow;
  logic                allDone;

`ifdef IR_INPUT_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;

  // Idle level of a charged line is high, so the synchroniser resets to 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_signal;
      sync2 <= sync1;
    end
  end
  assign inSync = sync2;
`else
  assign inSync = in_signal;
`endif

  assign hitNow    = ~captured & ~inSync;
  assign allDone   = &(captured | ~inSync);
  assign drive_out = {CHANNELS{state == CHARGE}};
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (enable) nextState = CHARGE;
      CHARGE:  if (chargeCnt == KW'(CHARGE_CYCLES - 1)) nextState = MEASURE;
      MEASURE: if (allDone || measCnt == CW'(TIMEOUT)) nextState = PUBLISH;
      PUBLISH: nextState = enable ? CHARGE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Channels still high when the window closes are stamped with TIMEOUT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chargeCnt    <= '0;
      measCnt      <= '0;
      captured     <= '0;
      times        <= '0;
      black        <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        capVal[i] <= '0;
        hitCnt[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: chargeCnt <= '0;
        CHARGE: begin
          chargeCnt <= chargeCnt + KW'(1);
          measCnt   <= '0;
          captured  <= '0;
        end
        MEASURE: begin
          if (measCnt != CW'(TIMEOUT)) measCnt <= measCnt + CW'(1);
          for (int i = 0; i < CHANNELS; i++) begin
            if (hitNow[i]) begin
              capVal[i]   <= measCnt;
              captured[i] <= 1'b1;
            end else if (!captured[i] && nextState == PUBLISH) begin
              capVal[i] <= CW'(TIMEOUT);
            end
          end
        end
        PUBLISH: begin
          sample_valid <= 1'b1;
          chargeCnt    <= '0;
          for (int i = 0; i < CHANNELS; i++) begin
            times[i*CW +: CW] <= capVal[i];
            if (capVal[i] >= CW'(THRESHOLD)) begin
              if (hitCnt[i] != 6'(BLACK_HITS)) hitCnt[i] <= hitCnt[i] + 6'd1;
              black[i] <= (hitCnt[i] >= 6'(BLACK_HITS - 1));
            end else begin
              hitCnt[i] <= '0;
              black[i]  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_array_sampler.sv
`timescale 1ns/1ps
// Scoreboard bench for ir_array_sampler: directed discharge vectors push expected samples, a monitor checks each sample_valid.
module tb_ir_array_sampler;

  localparam int CH = 4;
  localparam int CC = 8;
  localparam int TO = 20;
  localparam int TH = 10;
  localparam int BH = 3;
  localparam int CW = 5;
  localparam int NEVER = 99;
`ifdef IR_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [CH*CW-1:0] t;
    logic [CH-1:0]    b;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [CH-1:0]    in_signal = '1;
  logic [CH-1:0]    drive_out;
  logic [CH*CW-1:0] times;
  logic [CH-1:0]    black;
  logic             sample_valid;
  logic             busy;

  exp_t expQ[$];
  int   checks = 0;
  int   fails = 0;
  int   bhits[CH];
  bit   prevValid = 1'b0;

  ir_array_sampler #(
    .CHANNELS(CH), .CHARGE_CYCLES(CC), .TIMEOUT(TO), .THRESHOLD(TH), .BLACK_HITS(BH)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_signal(in_signal),
    .drive_out(drive_out), .times(times), .black(black),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL unexpectedSample: got sample_valid with empty queue, expected none");
    end else begin
      e = expQ.pop_front();
      for (int i = 0; i < CH; i++)
        check($sformatf("times[%0d]", i), int'(times[i*CW +: CW]), int'(e.t[i*CW +: CW]));
      check("black", int'(black), int'(e.b));
    end
  endtask

  // Monitor: compare every published sample against the head of the queue.
  always @(posedge clock) begin
    #1;
    if (reset && sample_valid) begin
      checkOutput();
      if (prevValid) check("validPulseWidth", 2, 1);
    end
    prevValid = sample_valid;
  end

  // Runs one full sampling cycle with channel i falling at measure count f[i].
  task automatic applyStimulus(input int f0, input int f1, input int f2, input int f3,
                               input bit dropEnable);
    int   f[CH];
    int   t, maxT, guard, highCnt, k;
    exp_t e;
    f = '{f0, f1, f2, f3};
    maxT = 0;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      t = f[i] + LAT;
      if (t > TO) t = TO;
      e.t[i*CW +: CW] = CW'(t);
      if (t >= TH) begin
        if (bhits[i] < BH) bhits[i]++;
      end else begin
        bhits[i] = 0;
      end
      e.b[i] = (bhits[i] >= BH);
      if (t > maxT) maxT = t;
    end
    expQ.push_back(e);

    guard = 0;
    while (drive_out != '1 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 100) begin
      check("chargeStartTimeout", 0, 1);
      return;
    end
    if (dropEnable) enable = 1'b0;
    highCnt = 0;
    while (drive_out == '1 && highCnt < 100) begin
      highCnt++;
      @(posedge clock); #1;
    end
    check("chargeLen", highCnt, CC);
    check("driveLowInMeasure", int'(drive_out), 0);

    k = 0;
    for (int i = 0; i < CH; i++) in_signal[i] = (k < f[i]);
    while (k < 60) begin
      @(posedge clock); #1;
      k++;
      if (sample_valid) break;
      for (int i = 0; i < CH; i++) in_signal[i] = (k < f[i]);
    end
    in_signal = '1;
    check("measureLen", k, maxT + 2);
  endtask

  initial begin
    int highSeen;
    int guard;
    for (int i = 0; i < CH; i++) bhits[i] = 0;
    #12;
    check("rstDrive", int'(drive_out), 0);
    check("rstTimes", int'(times), 0);
    check("rstBlack", int'(black), 0);
    check("rstValid", int'(sample_valid), 0);
    check("rstBusy", int'(busy), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("idleBusy", int'(busy), 0);
    enable = 1'b1;

    applyStimulus(0, 0, 0, 0, 1'b0);
    applyStimulus(3, 9, 10, NEVER, 1'b0);
    applyStimulus(1, 2, 3, 4, 1'b0);
    applyStimulus(2, 2, 15, 2, 1'b0);
    applyStimulus(2, 2, 15, 2, 1'b0);
    applyStimulus(2, 2, 15, 2, 1'b0);
    applyStimulus(5, 3, 4, 2, 1'b0);
    applyStimulus(12, 12, 12, 12, 1'b0);
    applyStimulus(12, 12, 12, 12, 1'b0);
    applyStimulus(12, 12, 12, 12, 1'b1);

    check("stopBusy", int'(busy), 0);
    check("stopDrive", int'(drive_out), 0);
    highSeen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (drive_out != '0 || busy) highSeen++;
    end
    check("staysIdle", highSeen, 0);

    // Reset in the middle of a measurement window.
    enable = 1'b1;
    guard = 0;
    while (drive_out != '1 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    while (drive_out == '1 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    check("reachMeasure", int'(guard < 100), 1);
    repeat (3) @(posedge clock);
    #3;
    check("measureBusy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("midRstDrive", int'(drive_out), 0);
    check("midRstTimes", int'(times), 0);
    check("midRstBlack", int'(black), 0);
    check("midRstBusy", int'(busy), 0);
    check("midRstValid", int'(sample_valid), 0);
    enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("queueDrained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
